execute_writeback_pipe: RTL and testbench

Back half of the RISC-V pipeline. It takes the instruction leaving the ID/EX register, after the ALU, and carries it through the EX/MEM and MEM/WB pipeline registers. It drives the data-memory port and the register-file write port, which are the writer end of the register-file interface that the decode stage reads. It also computes forwarding selects and a load-use hazard flag for the instruction currently in EX, and counts retired instructions.

---
 rtl/execute_writeback_pipe_pkg.sv | 46 ++++
 rtl/execute_writeback_pipe_if.sv | 27 ++
 rtl/execute_writeback_pipe_forwarding_unit.sv | 55 +++++
 rtl/execute_writeback_pipe.sv | 121 ++++++++++++
 tb/tb_execute_writeback_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_writeback_pipe_pkg.sv
// Shared types and constants for the EX/MEM/WB back half of the pipeline.
// Imported by the forwarding unit and the pipe top.
package execute_writeback_pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    reg_idx_t    rd;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    reg_idx_t    rd;
    logic [31:0] alu_result;
    logic [31:0] rdata;
  } mem_wb_t;

  // A stage produces rs when it writes a non-x0 rd equal to rs.
  function automatic logic rd_hit(
    input logic     v,
    input logic     w,
    input reg_idx_t rd,
    input reg_idx_t rs
  );
    return v & w & (rd != '0) & (rd == rs);
  endfunction

endpackage

// File: rtl/execute_writeback_pipe_if.sv
// Data-memory port between the pipe (master) and the data memory (slave).
// Read data is combinational and sampled in the same cycle.
interface execute_writeback_pipe_if;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_addr_o,
    output mem_wdata_o,
    output mem_read_o,
    output mem_write_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_read_o,
    input  mem_write_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/execute_writeback_pipe_forwarding_unit.sv
// Combinational operand-forwarding selects and load-use detection
// for the instruction in EX, from the EX/MEM and MEM/WB stage fields.
module execute_writeback_pipe_forwarding_unit
  import execute_writeback_pipe_pkg::*;
(
  input  logic       exmem_valid,
  input  logic       exmem_reg_write,
  input  logic       exmem_mem_read,
  input  reg_idx_t   exmem_rd,
  input  logic       memwb_valid,
  input  logic       memwb_reg_write,
  input  reg_idx_t   memwb_rd,
  input  logic       ex_valid,
  input  reg_idx_t   rs1,
  input  reg_idx_t   rs2,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       load_use
);

  logic ex_a, ex_b, wb_a, wb_b;
  logic ld_a, ld_b;

  // A load in EX/MEM has no data yet, so it never forwards from there.
  assign ex_a = rd_hit(exmem_valid, exmem_reg_write & ~exmem_mem_read,
                       exmem_rd, rs1);
  assign ex_b = rd_hit(exmem_valid, exmem_reg_write & ~exmem_mem_read,
                       exmem_rd, rs2);
  assign wb_a = rd_hit(memwb_valid, memwb_reg_write, memwb_rd, rs1);
  assign wb_b = rd_hit(memwb_valid, memwb_reg_write, memwb_rd, rs2);

  assign ld_a = rd_hit(exmem_valid, exmem_mem_read, exmem_rd, rs1);
  assign ld_b = rd_hit(exmem_valid, exmem_mem_read, exmem_rd, rs2);

  always_comb begin
    fwd_a = FWD_NONE;
    priority case (1'b1)
      ex_a:    fwd_a = FWD_EXMEM;
      wb_a:    fwd_a = FWD_MEMWB;
      default: fwd_a = FWD_NONE;
    endcase
  end

  always_comb begin
    fwd_b = FWD_NONE;
    priority case (1'b1)
      ex_b:    fwd_b = FWD_EXMEM;
      wb_b:    fwd_b = FWD_MEMWB;
      default: fwd_b = FWD_NONE;
    endcase
  end

  assign load_use = ex_valid & (ld_a | ld_b);

endmodule

// File: rtl/execute_writeback_pipe.sv
// EX/MEM and MEM/WB pipeline registers, data-memory and register-file
// write ports, forwarding/load-use flags and a retired-instruction counter.
module execute_writeback_pipe
  import execute_writeback_pipe_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   ex_valid_i,
  input  logic [31:0]            ex_alu_result_i,
  input  logic [31:0]            ex_store_data_i,
  input  reg_idx_t               ex_rd_i,
  input  logic                   ex_reg_write_i,
  input  logic                   ex_mem_read_i,
  input  logic                   ex_mem_write_i,
  input  logic                   ex_mem_to_reg_i,
  input  reg_idx_t               ex_rs1_i,
  input  reg_idx_t               ex_rs2_i,
  execute_writeback_pipe_if.master dmem,
  output logic                   wb_reg_write_o,
  output reg_idx_t               wb_rd_o,
  output logic [31:0]            wb_data_o,
  output logic [1:0]             fwd_a_o,
  output logic [1:0]             fwd_b_o,
  output logic [31:0]            fwd_exmem_data_o,
  output logic                   load_use_o,
  output logic [COUNT_WIDTH-1:0] retired_count_o
);

  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  ex_mem_t exmem, exmem_next;
  mem_wb_t memwb, memwb_next;
  logic [COUNT_WIDTH-1:0] count;

  logic [1:0] fa, fb;
  logic       lu;

  // Control bits are stored ANDed with valid so bubbles are inert.
  always_comb begin
    exmem_next            = '0;
    exmem_next.valid      = ex_valid_i;
    exmem_next.reg_write  = ex_valid_i & ex_reg_write_i;
    exmem_next.mem_read   = ex_valid_i & ex_mem_read_i;
    exmem_next.mem_write  = ex_valid_i & ex_mem_write_i;
    exmem_next.mem_to_reg = ex_valid_i & ex_mem_to_reg_i;
    exmem_next.rd         = ex_rd_i;
    exmem_next.alu_result = ex_alu_result_i;
    exmem_next.store_data = ex_store_data_i;
  end

  always_comb begin
    memwb_next            = '0;
    memwb_next.valid      = exmem.valid;
    memwb_next.reg_write  = exmem.valid & exmem.reg_write;
    memwb_next.mem_to_reg = exmem.valid & exmem.mem_to_reg;
    memwb_next.rd         = exmem.rd;
    memwb_next.alu_result = exmem.alu_result;
    memwb_next.rdata      = dmem.mem_rdata_i;
  end

  // Flush beats stall for EX/MEM; MEM/WB still drains on a flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exmem <= '0;
      memwb <= '0;
      count <= '0;
    end else begin
      if (flush_i) begin
        exmem <= '0;
      end else if (!stall_i) begin
        exmem <= exmem_next;
      end
      if (flush_i || !stall_i) begin
        memwb <= memwb_next;
      end
      if (memwb.valid && !stall_i) begin
        count <= count + ONE;
      end
    end
  end

  execute_writeback_pipe_forwarding_unit u_fwd (
    .exmem_valid     (exmem.valid),
    .exmem_reg_write (exmem.reg_write),
    .exmem_mem_read  (exmem.mem_read),
    .exmem_rd        (exmem.rd),
    .memwb_valid     (memwb.valid),
    .memwb_reg_write (memwb.reg_write),
    .memwb_rd        (memwb.rd),
    .ex_valid        (ex_valid_i),
    .rs1             (ex_rs1_i),
    .rs2             (ex_rs2_i),
    .fwd_a           (fa),
    .fwd_b           (fb),
    .load_use        (lu)
  );

  // Outputs read as zero for the whole time reset is held low.
  assign dmem.mem_addr_o  = reset ? exmem.alu_result : '0;
  assign dmem.mem_wdata_o = reset ? exmem.store_data : '0;
  assign dmem.mem_read_o  = reset & exmem.valid & exmem.mem_read;
  assign dmem.mem_write_o = reset & exmem.valid & exmem.mem_write;

  assign wb_reg_write_o = reset & memwb.valid & memwb.reg_write
                          & (memwb.rd != '0);
  assign wb_rd_o        = reset ? memwb.rd : '0;
  assign wb_data_o      = !reset ? '0
                        : memwb.mem_to_reg ? memwb.rdata
                        : memwb.alu_result;

  assign fwd_a_o          = reset ? fa : FWD_NONE;
  assign fwd_b_o          = reset ? fb : FWD_NONE;
  assign fwd_exmem_data_o = reset ? exmem.alu_result : '0;
  assign load_use_o       = reset & lu;
  assign retired_count_o  = reset ? count : '0;

endmodule

// File: tb/tb_execute_writeback_pipe.sv
// Directed bench for execute_writeback_pipe with a writeback scoreboard.
// Expected register writes are queued at issue and popped at retirement.
module tb_execute_writeback_pipe;

  logic        clk;
  logic        reset;
  logic        stall, flush;
  logic        ex_valid;
  logic [31:0] ex_alu, ex_sd;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_rw, ex_mr, ex_mw, ex_m2r;

  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] fwd_data;
  logic        load_use;
  logic [15:0] count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         q[$];
  int          tests;
  int          fails;
  logic [15:0] exp_cnt;

  execute_writeback_pipe_if dmem ();

  execute_writeback_pipe #(.COUNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall),
    .flush_i          (flush),
    .ex_valid_i       (ex_valid),
    .ex_alu_result_i  (ex_alu),
    .ex_store_data_i  (ex_sd),
    .ex_rd_i          (ex_rd),
    .ex_reg_write_i   (ex_rw),
    .ex_mem_read_i    (ex_mr),
    .ex_mem_write_i   (ex_mw),
    .ex_mem_to_reg_i  (ex_m2r),
    .ex_rs1_i         (ex_rs1),
    .ex_rs2_i         (ex_rs2),
    .dmem             (dmem),
    .wb_reg_write_o   (wb_we),
    .wb_rd_o          (wb_rd),
    .wb_data_o        (wb_data),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b),
    .fwd_exmem_data_o (fwd_data),
    .load_use_o       (load_use),
    .retired_count_o  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    ex_valid = v;
    ex_alu   = alu;
    ex_sd    = sd;
    ex_rd    = rd;
    ex_rw    = rw;
    ex_mr    = mr;
    ex_mw    = mw;
    ex_m2r   = m2r;
    ex_rs1   = rs1;
    ex_rs2   = rs2;
    if (v) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_t e;
    e.rd   = rd;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_we"},    {31'd0, wb_we},              32'd0);
    check({tag, "_rd"},    {27'd0, wb_rd},              32'd0);
    check({tag, "_wbd"},   wb_data,                     32'd0);
    check({tag, "_addr"},  dmem.mem_addr_o,             32'd0);
    check({tag, "_wdat"},  dmem.mem_wdata_o,            32'd0);
    check({tag, "_mrd"},   {31'd0, dmem.mem_read_o},    32'd0);
    check({tag, "_mwr"},   {31'd0, dmem.mem_write_o},   32'd0);
    check({tag, "_fa"},    {30'd0, fwd_a},              32'd0);
    check({tag, "_fb"},    {30'd0, fwd_b},              32'd0);
    check({tag, "_fdat"},  fwd_data,                    32'd0);
    check({tag, "_lu"},    {31'd0, load_use},           32'd0);
    check({tag, "_cnt"},   {16'd0, count},              32'd0);
  endtask

  // Scoreboard: a register write is consumed on edges where MEM/WB moves.
  always @(negedge clk) begin
    if (reset && (!stall || flush) && wb_we) begin
      if (q.size() == 0) begin
        check("sb_unexpected_rd", {27'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = q.pop_front();
        check("sb_rd",   {27'd0, wb_rd}, {27'd0, e.rd});
        check("sb_data", wb_data,        e.data);
      end
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = '0;
    reset   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    dmem.mem_rdata_i = '0;
    idle();

    @(negedge clk);
    chk_zero("rst");
    tick();
    tick();
    reset = 1'b1;

    // Single ALU writer to x5
    drive(1, 32'h11, 0, 5, 1, 0, 0, 0, 0, 0);
    expect_wb(5, 32'h11);
    tick();
    idle();
    @(negedge clk);
    check("add_maddr", dmem.mem_addr_o, 32'h11);
    check("add_mrd", {31'd0, dmem.mem_read_o}, 32'd0);
    check("add_cnt0", {16'd0, count}, 32'd0);
    tick();
    @(negedge clk);
    check("add_we", {31'd0, wb_we}, 32'd1);
    check("add_rd", {27'd0, wb_rd}, 32'd5);
    check("add_data", wb_data, 32'h11);
    tick();
    @(negedge clk);
    check("add_cnt1", {16'd0, count}, {16'd0, exp_cnt});
    tick();

    // Load to x6 followed by a dependent reader
    drive(1, 32'h40, 0, 6, 1, 1, 0, 1, 0, 0);
    expect_wb(6, 32'hDEAD_BEEF);
    tick();
    drive(1, 32'h99, 0, 7, 1, 0, 0, 0, 6, 2);
    expect_wb(7, 32'h99);
    dmem.mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ld_mrd", {31'd0, dmem.mem_read_o}, 32'd1);
    check("ld_addr", dmem.mem_addr_o, 32'h40);
    check("ld_use", {31'd0, load_use}, 32'd1);
    check("ld_fa", {30'd0, fwd_a}, 32'd0);
    tick();
    idle();
    dmem.mem_rdata_i = '0;
    @(negedge clk);
    check("ld_wbd", wb_data, 32'hDEAD_BEEF);
    check("ld_wbrd", {27'd0, wb_rd}, 32'd6);
    check("ld_use_off", {31'd0, load_use}, 32'd0);
    tick();
    tick();

    // Back-to-back writers to x3 forward from EX/MEM
    drive(1, 32'h100, 0, 3, 1, 0, 0, 0, 0, 0);
    expect_wb(3, 32'h100);
    tick();
    drive(1, 32'h200, 0, 3, 1, 0, 0, 0, 0, 0);
    expect_wb(3, 32'h200);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    @(negedge clk);
    check("b2b_fa", {30'd0, fwd_a}, 32'd2);
    check("b2b_fb", {30'd0, fwd_b}, 32'd2);
    check("b2b_fdat", fwd_data, 32'h200);
    check("b2b_lu", {31'd0, load_use}, 32'd0);
    tick();

    // Writer, bubble, reader: forward from MEM/WB
    drive(1, 32'h300, 0, 3, 1, 0, 0, 0, 0, 0);
    expect_wb(3, 32'h300);
    tick();
    idle();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    check("bub_fa", {30'd0, fwd_a}, 32'd1);
    check("bub_fb", {30'd0, fwd_b}, 32'd0);
    tick();
    idle();
    tick();
    tick();

    // Writer to x0 never writes or forwards
    drive(1, 32'h5, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("x0_fa", {30'd0, fwd_a}, 32'd0);
    check("x0_fb", {30'd0, fwd_b}, 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("x0_we", {31'd0, wb_we}, 32'd0);
    tick();
    tick();
    @(negedge clk);
    check("cnt_mid", {16'd0, count}, {16'd0, exp_cnt});
    tick();

    // Store held in EX/MEM across a 3-cycle stall
    drive(1, 32'h80, 32'hCAFE, 0, 0, 0, 1, 0, 0, 0);
    tick();
    idle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_mwr", {31'd0, dmem.mem_write_o}, 32'd1);
      check("st_addr", dmem.mem_addr_o, 32'h80);
      check("st_wdat", dmem.mem_wdata_o, 32'hCAFE);
      check("st_cnt", {16'd0, count}, {16'd0, exp_cnt - 16'd1});
      tick();
    end
    stall = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    check("st_cnt_after", {16'd0, count}, {16'd0, exp_cnt});
    tick();

    // Flush during stall: EX/MEM bubbles, MEM/WB still advances
    drive(1, 32'h999, 0, 9, 1, 0, 0, 0, 0, 0);
    expect_wb(9, 32'h999);
    tick();
    drive(1, 32'h777, 0, 10, 1, 0, 0, 0, 0, 0);
    exp_cnt = exp_cnt - 16'd1;
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_addr", dmem.mem_addr_o, 32'h999);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("fl_we", {31'd0, wb_we}, 32'd1);
    check("fl_rd", {27'd0, wb_rd}, 32'd9);
    check("fl_data", wb_data, 32'h999);
    check("fl_bub_addr", dmem.mem_addr_o, 32'd0);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("fl_cnt", {16'd0, count}, {16'd0, exp_cnt});
    tick();

    // Reset with two instructions in flight
    drive(1, 32'hAAA, 0, 11, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 32'hBBB, 0, 12, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    tick();
    reset = 1'b1;
    exp_cnt = '0;
    drive(1, 32'hCCC, 0, 13, 1, 0, 0, 0, 0, 0);
    expect_wb(13, 32'hCCC);
    @(negedge clk);
    check("rr_we0", {31'd0, wb_we}, 32'd0);
    tick();
    idle();
    tick();
    @(negedge clk);
    check("rr_we", {31'd0, wb_we}, 32'd1);
    check("rr_rd", {27'd0, wb_rd}, 32'd13);
    check("rr_data", wb_data, 32'hCCC);
    tick();

    // Bring the counter to all-ones minus one, then wrap
    for (int i = 0; i < 65533; i++) begin
      drive(1, i, 0, 0, 1, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    tick();
    tick();
    tick();
    @(negedge clk);
    check("cnt_fffe", {16'd0, count}, 32'h0000_FFFE);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    tick();
    tick();
    tick();
    @(negedge clk);
    check("cnt_wrap", {16'd0, count}, {16'd0, exp_cnt});
    check("cnt_wrap0", {16'd0, count}, 32'd0);
    check("sb_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
